// File: rtl/ber_pkg.sv
// Shared constants and types for the BER checker slice.
//   - PRBS9 (x^9 + x^5 + 1) tap positions, seed and next-state helper
//   - FSM state encoding (ST_SEARCH, ST_LOCK)
//   - default window / relock threshold constants
package ber_pkg;

  localparam logic [8:0]  PRBS9_SEED     = 9'h1FF;
  localparam int unsigned PRBS9_TAP_HI   = 8;   // x^9 term
  localparam int unsigned PRBS9_TAP_LO   = 4;   // x^5 term
  localparam int unsigned DEF_NB_WIN     = 7;
  localparam int unsigned DEF_RELOCK_THR = 16;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCK   = 1'b1
  } ber_state_t;

  // Fibonacci form: output is the MSB, feedback enters at the LSB.
  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO]};
  endfunction

endpackage

// File: rtl/ber_prbs9_ref.sv
// Local PRBS9 reference generator.
// Ports:
//   clock      system clock
//   i_reset    asynchronous active-high reset (state -> PRBS9_SEED)
//   i_advance  step the sequence by one bit
//   o_bit      current sequence bit (valid before the step)
module ber_prbs9_ref
  import ber_pkg::*;
(
  input  logic clock,
  input  logic i_reset,
  input  logic i_advance,
  output logic o_bit
);

  logic [8:0] state;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= PRBS9_SEED;
    end else if (i_advance) begin
      state <= prbs9_next(state);
    end
  end

  assign o_bit = state[8];

endmodule

// File: rtl/ber_checker.sv
// Receive-side BER checker behind the FIR shaping filter: decimates at a
// selectable phase, slices the sign, aligns a local PRBS9 reference by delay
// search and counts bits/errors while locked.
// Optional feature macro: BER_RELOCK_EN (per-window error tally drops lock).
// Ports:
//   clock, i_reset           clock, asynchronous active-high reset
//   i_enable                 0 freezes the front end, strobes are ignored
//   i_valid, i_data          filter sample strobe and sample
//   i_phase                  sampling phase within a symbol
//   i_clear                  synchronous clear of bit/error counters
//   o_dec_bit, o_dec_valid   sliced decision and its 1-cycle strobe
//   o_locked, o_delay        alignment status and reference delay
//   o_bit_count, o_err_count saturating counters while locked
module ber_checker
  import ber_pkg::*;
#(
  parameter int unsigned NB_DATA    = 13,
  parameter int unsigned N_OS       = 4,
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned NB_WIN     = DEF_NB_WIN,
  parameter int unsigned NB_CNT     = 32,
  parameter int unsigned RELOCK_THR = DEF_RELOCK_THR
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic [NB_DATA-1:0]           i_data,
  input  logic [$clog2(N_OS)-1:0]      i_phase,
  input  logic                         i_clear,
  output logic                         o_dec_bit,
  output logic                         o_dec_valid,
  output logic                         o_locked,
  output logic [$clog2(MAX_DELAY)-1:0] o_delay,
  output logic [NB_CNT-1:0]            o_bit_count,
  output logic [NB_CNT-1:0]            o_err_count
);

  localparam int unsigned NB_PH  = $clog2(N_OS);
  localparam int unsigned NB_DLY = $clog2(MAX_DELAY);

  function automatic logic [NB_DLY-1:0] delay_next(input logic [NB_DLY-1:0] d);
    return (d == NB_DLY'(MAX_DELAY - 1)) ? '0 : d + 1'b1;
  endfunction

  // Only the sign bit is sliced.
  logic unused_data_bits;
  assign unused_data_bits = ^i_data[NB_DATA-2:0];

  // Phase counter and slicer
  logic [NB_PH-1:0] phase_cnt;
  logic             qual;

  assign qual = i_enable && i_valid && (phase_cnt == i_phase);

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      phase_cnt   <= '0;
      o_dec_bit   <= 1'b0;
      o_dec_valid <= 1'b0;
    end else begin
      if (i_enable && i_valid) begin
        phase_cnt <= phase_cnt + 1'b1;
      end
      o_dec_valid <= qual;
      if (qual) begin
        o_dec_bit <= i_data[NB_DATA-1];
      end
    end
  end

  // Reference: tap 0 is the live PRBS bit, tap i is the bit from i decisions ago.
  logic                 prbs_bit;
  logic [MAX_DELAY-2:0] hist;
  logic [MAX_DELAY-1:0] ref_taps;
  logic                 err_bit;
  logic                 err_valid;

  ber_prbs9_ref u_prbs (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_advance (o_dec_valid),
    .o_bit     (prbs_bit)
  );

  assign ref_taps = {hist, prbs_bit};

  // Decisions already sliced still drain through this stage when i_enable
  // drops, so no decision is ever half-processed.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      hist      <= '0;
      err_bit   <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= o_dec_valid;
      if (o_dec_valid) begin
        err_bit <= o_dec_bit ^ ref_taps[o_delay];
        hist    <= ref_taps[MAX_DELAY-2:0];
      end
    end
  end

  // Alignment FSM, stepped once per compared decision
  ber_state_t        state;
  logic [NB_WIN-1:0] win_cnt;
  logic              win_err;
  logic              win_last;

  assign win_last = (win_cnt == '1);

`ifdef BER_RELOCK_EN
  localparam int unsigned NB_TALLY = $clog2(RELOCK_THR + 1);
  logic [NB_TALLY-1:0] win_tally;
  logic [NB_TALLY-1:0] tally_nxt;

  always_comb begin
    tally_nxt = (win_tally >= NB_TALLY'(RELOCK_THR)) ? win_tally
                                                      : win_tally + NB_TALLY'(err_bit);
  end
`else
  localparam int unsigned UNUSED_RELOCK_THR = RELOCK_THR;
`endif

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_SEARCH;
      win_cnt  <= '0;
      win_err  <= 1'b0;
      o_locked <= 1'b0;
      o_delay  <= '0;
`ifdef BER_RELOCK_EN
      win_tally <= '0;
`endif
    end else if (err_valid) begin
      win_cnt <= win_cnt + 1'b1;
      unique case (state)
        ST_SEARCH: begin
          if (win_last) begin
            win_err <= 1'b0;
            if (!win_err && !err_bit) begin
              state    <= ST_LOCK;
              o_locked <= 1'b1;
            end else begin
              o_delay <= delay_next(o_delay);
            end
          end else begin
            win_err <= win_err | err_bit;
          end
        end
        ST_LOCK: begin
`ifdef BER_RELOCK_EN
          if (win_last) begin
            win_tally <= '0;
            if (tally_nxt >= NB_TALLY'(RELOCK_THR)) begin
              state    <= ST_SEARCH;
              o_locked <= 1'b0;
              o_delay  <= delay_next(o_delay);
            end
          end else begin
            win_tally <= tally_nxt;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Saturating counters; clear takes priority over an increment.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (i_clear) begin
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (err_valid && (state == ST_LOCK)) begin
      if (o_bit_count != '1) begin
        o_bit_count <= o_bit_count + 1'b1;
      end
      if (err_bit && (o_err_count != '1)) begin
        o_err_count <= o_err_count + 1'b1;
      end
    end
  end

endmodule
